vdp_tile_fetch_scheduler: RTL and testbench

Sequences per-line VRAM fetches for the VDP tile layers. For each tile column and each enabled layer it issues a map-word read, waits one cycle so the tile address generator can register the returned map data, then issues the tile-row read at the generated tile address. It arbitrates with the VRAM port owner through a request/grant handshake, and tags each returned tile word with its layer and column for the pixel pipeline.

---
 rtl/vdp_tile_fetch_scheduler.sv | 231 +++++++++++++++++++++++
 tb/tb_vdp_tile_fetch_scheduler.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vdp_tile_fetch_scheduler.sv
// ---------------------------------------------------------------------------
// vdp_tile_fetch_scheduler
//
// Sequences the per-line VRAM fetches for the VDP tile layers. For every tile
// column (outer loop) and every enabled layer (inner loop, ascending) it
// issues a map-word read, spends one cycle in MAP_WAIT while the external
// tile address generator registers the returned map word, then issues the
// tile-row read at the generated address. Each returned tile row is tagged
// with its layer and column one cycle after its grant.
//
// Ports
//   clk              pixel-domain clock
//   reset            asynchronous, active-high
//   line_start       one-cycle pulse starting a line (ignored while busy)
//   layer_enable     per-layer enable, captured on the accepted line_start
//   vram_grant       VRAM owner accepts the current request this cycle
//   vram_req         fetch request
//   fetch_kind       0 = map word read, 1 = tile row read
//   layer_index      layer of the current request
//   column           column of the current request
//   tile_data_valid  vram_data holds a tile row this cycle
//   tile_layer       layer tag for tile_data_valid
//   tile_column      column tag for tile_data_valid
//   busy             a line's sequence is in progress
//   done             one-cycle pulse when the line's sequence ends
//   state_dbg        current FSM state (IDLE=0, MAP_REQ=1, MAP_WAIT=2,
//                    TILE_REQ=3)
//
// Handshake: a request is transferred in a cycle where vram_req=1 and
// vram_grant=1. Once raised, vram_req, fetch_kind, layer_index and column
// hold steady until that transfer; a request is never withdrawn ungranted,
// and vram_grant is ignored whenever vram_req=0. Read data appears on
// vram_data exactly one cycle after the granting cycle.
// ---------------------------------------------------------------------------
module vdp_tile_fetch_scheduler #(
    parameter int LAYERS  = 4,
    parameter int COLUMNS = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              line_start,
    input  logic [LAYERS-1:0] layer_enable,
    input  logic              vram_grant,
    output logic              vram_req,
    output logic              fetch_kind,
    output logic [1:0]        layer_index,
    output logic [5:0]        column,
    output logic              tile_data_valid,
    output logic [1:0]        tile_layer,
    output logic [5:0]        tile_column,
    output logic              busy,
    output logic              done,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MAP_REQ  = 2'd1,
        ST_MAP_WAIT = 2'd2,
        ST_TILE_REQ = 2'd3
    } state_t;

    localparam logic [5:0] LAST_COL = 6'(COLUMNS - 1);

    // Lowest set bit of the enable mask (0 when the mask is empty).
    function automatic logic [1:0] lowest_layer(input logic [LAYERS-1:0] en);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = LAYERS - 1; i >= 0; i--) begin
            if (en[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

    // Next enabled layer strictly above cur: {found, index}. Scanning from the
    // top down leaves the closest one above cur in idx.
    function automatic logic [2:0] next_layer(input logic [LAYERS-1:0] en,
                                              input logic [1:0]        cur);
        logic       found;
        logic [1:0] idx;
        found = 1'b0;
        idx   = 2'd0;
        for (int i = LAYERS - 1; i >= 0; i--) begin
            if (en[i] && (i > int'(cur))) begin
                found = 1'b1;
                idx   = 2'(i);
            end
        end
        return {found, idx};
    endfunction

    state_t            state_q, state_d;
    logic [LAYERS-1:0] en_q, en_d;
    logic              vram_req_q, vram_req_d;
    logic              fetch_kind_q, fetch_kind_d;
    logic [1:0]        layer_q, layer_d;
    logic [5:0]        column_q, column_d;
    logic              tdv_q, tdv_d;
    logic [1:0]        tile_layer_q, tile_layer_d;
    logic [5:0]        tile_column_q, tile_column_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [2:0]        nxt;

    always_comb begin
        state_d       = state_q;
        en_d          = en_q;
        vram_req_d    = vram_req_q;
        fetch_kind_d  = fetch_kind_q;
        layer_d       = layer_q;
        column_d      = column_q;
        tdv_d         = 1'b0;
        tile_layer_d  = tile_layer_q;
        tile_column_d = tile_column_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        nxt           = next_layer(en_q, layer_q);

        case (state_q)
            ST_IDLE: begin
                if (line_start) begin
                    if (|layer_enable) begin
                        // The mask is frozen here; mid-line enable changes
                        // must not disturb the sequence.
                        en_d         = layer_enable;
                        column_d     = 6'd0;
                        layer_d      = lowest_layer(layer_enable);
                        vram_req_d   = 1'b1;
                        fetch_kind_d = 1'b0;
                        busy_d       = 1'b1;
                        state_d      = ST_MAP_REQ;
                    end else begin
                        // Nothing to fetch: the line ends immediately.
                        done_d = 1'b1;
                    end
                end
            end

            ST_MAP_REQ: begin
                if (vram_grant) begin
                    vram_req_d = 1'b0;
                    state_d    = ST_MAP_WAIT;
                end
            end

            ST_MAP_WAIT: begin
                // Map word is on vram_data now and the generator registers
                // it; its tile_address is valid from the next cycle.
                vram_req_d   = 1'b1;
                fetch_kind_d = 1'b1;
                state_d      = ST_TILE_REQ;
            end

            ST_TILE_REQ: begin
                if (vram_grant) begin
                    // Tag the tile row that returns next cycle.
                    tdv_d         = 1'b1;
                    tile_layer_d  = layer_q;
                    tile_column_d = column_q;
                    fetch_kind_d  = 1'b0;
                    if (nxt[2]) begin
                        layer_d    = nxt[1:0];
                        vram_req_d = 1'b1;
                        state_d    = ST_MAP_REQ;
                    end else if (column_q == LAST_COL) begin
                        // Last tile of the line: done and busy-fall line up
                        // with its tile_data_valid.
                        layer_d    = 2'd0;
                        column_d   = 6'd0;
                        vram_req_d = 1'b0;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        column_d   = column_q + 6'd1;
                        layer_d    = lowest_layer(en_q);
                        vram_req_d = 1'b1;
                        state_d    = ST_MAP_REQ;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            en_q          <= '0;
            vram_req_q    <= 1'b0;
            fetch_kind_q  <= 1'b0;
            layer_q       <= 2'd0;
            column_q      <= 6'd0;
            tdv_q         <= 1'b0;
            tile_layer_q  <= 2'd0;
            tile_column_q <= 6'd0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            en_q          <= en_d;
            vram_req_q    <= vram_req_d;
            fetch_kind_q  <= fetch_kind_d;
            layer_q       <= layer_d;
            column_q      <= column_d;
            tdv_q         <= tdv_d;
            tile_layer_q  <= tile_layer_d;
            tile_column_q <= tile_column_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign vram_req        = vram_req_q;
    assign fetch_kind      = fetch_kind_q;
    assign layer_index     = layer_q;
    assign column          = column_q;
    assign tile_data_valid = tdv_q;
    assign tile_layer      = tile_layer_q;
    assign tile_column     = tile_column_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign state_dbg       = state_q;

endmodule

// File: tb/tb_vdp_tile_fetch_scheduler.sv
// ---------------------------------------------------------------------------
// Testbench for vdp_tile_fetch_scheduler (LAYERS=4, COLUMNS=32).
// Inputs are driven and outputs sampled on the falling clock edge. Each line
// is described by one table record; the expected request and tag order is
// built from the enable mask before the line starts and popped as the DUT
// issues grants and tile tags. Hand-written sequences cover the empty-enable
// line and an asynchronous reset in mid-line.
// ---------------------------------------------------------------------------
module tb_vdp_tile_fetch_scheduler;

    localparam int COLS = 32;

    logic       clk;
    logic       reset;
    logic       line_start;
    logic [3:0] layer_enable;
    logic       vram_grant;
    logic       vram_req;
    logic       fetch_kind;
    logic [1:0] layer_index;
    logic [5:0] column;
    logic       tile_data_valid;
    logic [1:0] tile_layer;
    logic [5:0] tile_column;
    logic       busy;
    logic       done;
    logic [1:0] state_dbg;

    int total;
    int bad;

    // {fetch_kind, layer, column} of each expected granted request
    logic [8:0] exp_q[$];
    // {layer, column} of each expected tile_data_valid tag
    logic [7:0] tag_q[$];

    typedef struct {
        logic [3:0] en;
        int         stall_max;
        bit         disturb;
        int         exp_cycles;
    } vec_t;

    vec_t vecs[7];

    vdp_tile_fetch_scheduler #(
        .LAYERS (4),
        .COLUMNS(COLS)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .line_start     (line_start),
        .layer_enable   (layer_enable),
        .vram_grant     (vram_grant),
        .vram_req       (vram_req),
        .fetch_kind     (fetch_kind),
        .layer_index    (layer_index),
        .column         (column),
        .tile_data_valid(tile_data_valid),
        .tile_layer     (tile_layer),
        .tile_column    (tile_column),
        .busy           (busy),
        .done           (done),
        .state_dbg      (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic run_line(input logic [3:0] en, input int stall_max,
                            input bit disturb, input int exp_cycles);
        int         cyc;
        int         map_cyc;
        int         stalls;
        int         stall_cnt;
        bit         seen_done;
        bit         prev_req;
        bit         prev_grant;
        bit         prev_kind;
        bit         prev_tile_grant;
        logic [1:0] prev_layer;
        logic [5:0] prev_col;
        logic       g;
        logic [8:0] e9;
        logic [7:0] e8;

        exp_q.delete();
        tag_q.delete();
        for (int c = 0; c < COLS; c++) begin
            for (int l = 0; l < 4; l++) begin
                if (en[l]) begin
                    exp_q.push_back({1'b0, 2'(l), 6'(c)});
                    exp_q.push_back({1'b1, 2'(l), 6'(c)});
                    tag_q.push_back({2'(l), 6'(c)});
                end
            end
        end

        line_start   = 1'b1;
        layer_enable = en;
        vram_grant   = (stall_max == 0);
        @(negedge clk);
        line_start = 1'b0;

        map_cyc         = -100;
        stalls          = 0;
        stall_cnt       = -1;
        seen_done       = 1'b0;
        prev_req        = 1'b0;
        prev_grant      = 1'b0;
        prev_kind       = 1'b0;
        prev_tile_grant = 1'b0;
        prev_layer      = 2'd0;
        prev_col        = 6'd0;

        for (cyc = 0; cyc < 6000 && !seen_done; cyc++) begin
            if (cyc == 0) begin
                chk("first_req", 32'(vram_req), 1);
                chk("busy_start", 32'(busy), 1);
            end
            if (prev_req && !prev_grant) begin
                chk("req_held", 32'(vram_req), 1);
                chk("req_stable", 32'({fetch_kind, layer_index, column}),
                    32'({prev_kind, prev_layer, prev_col}));
            end
            if (vram_req && fetch_kind && !(prev_req && prev_kind)) begin
                chk("map_tile_gap_ge2", 32'((cyc - map_cyc) >= 2), 1);
            end
            chk("tdv_timing", 32'(tile_data_valid), 32'(prev_tile_grant));
            if (tile_data_valid) begin
                if (tag_q.size() == 0) begin
                    chk("tag_extra", 32'(tile_data_valid), 0);
                end else begin
                    e8 = tag_q.pop_front();
                    chk("tile_tag", 32'({tile_layer, tile_column}), 32'(e8));
                end
            end
            if (done) begin
                seen_done = 1'b1;
                chk("line_cycles", cyc, exp_cycles + stalls);
                chk("busy_at_done", 32'(busy), 0);
                chk("tdv_at_done", 32'(tile_data_valid), 1);
                chk("tags_left", tag_q.size(), 0);
                chk("reqs_left", exp_q.size(), 0);
            end

            if (disturb) begin
                if (cyc == 50) begin
                    line_start   = 1'b1;
                    layer_enable = ~en;
                end else if (cyc == 51) begin
                    line_start = 1'b0;
                end else if (cyc > 51) begin
                    layer_enable = 4'($urandom);
                end
            end

            if (vram_req) begin
                if (stall_max == 0) begin
                    g = 1'b1;
                end else begin
                    if (stall_cnt < 0) stall_cnt = $urandom_range(0, stall_max);
                    if (stall_cnt == 0) begin
                        g         = 1'b1;
                        stall_cnt = -1;
                    end else begin
                        g = 1'b0;
                        stall_cnt--;
                        stalls++;
                    end
                end
            end else begin
                // Grants with no request pending must be ignored.
                g = (stall_max == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            end
            vram_grant = g;

            if (vram_req && g) begin
                if (exp_q.size() == 0) begin
                    chk("req_extra", 32'(vram_req), 0);
                end else begin
                    e9 = exp_q.pop_front();
                    chk("req_order", 32'({fetch_kind, layer_index, column}), 32'(e9));
                end
                if (!fetch_kind) map_cyc = cyc;
            end

            prev_tile_grant = vram_req && g && fetch_kind;
            prev_req        = vram_req;
            prev_grant      = g;
            prev_kind       = fetch_kind;
            prev_layer      = layer_index;
            prev_col        = column;
            @(negedge clk);
        end

        chk("line_done_seen", 32'(seen_done), 1);
        chk("done_one_cycle", 32'(done), 0);
        chk("idle_no_req", 32'(vram_req), 0);
        chk("idle_not_busy", 32'(busy), 0);
        line_start   = 1'b0;
        vram_grant   = 1'b0;
        layer_enable = en;
        @(negedge clk);
    endtask

    initial begin
        bit found;

        total = 0;
        bad   = 0;

        vecs[0] = '{4'b1111, 0, 1'b0, 384};
        vecs[1] = '{4'b1010, 0, 1'b0, 192};
        vecs[2] = '{4'b1010, 5, 1'b0, 192};
        vecs[3] = '{4'b1111, 0, 1'b1, 384};
        vecs[4] = '{4'b0001, 3, 1'b1,  96};
        vecs[5] = '{4'b1000, 0, 1'b0,  96};
        vecs[6] = '{4'b0110, 2, 1'b0, 192};

        // Clock and reset
        reset        = 1'b1;
        line_start   = 1'b0;
        layer_enable = 4'b0000;
        vram_grant   = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_req", 32'(vram_req), 0);
        chk("rst_kind", 32'(fetch_kind), 0);
        chk("rst_layer_col", 32'({layer_index, column}), 0);
        chk("rst_tags", 32'({tile_data_valid, tile_layer, tile_column}), 0);
        chk("rst_busy_done", 32'({busy, done}), 0);
        chk("rst_state", 32'(state_dbg), 0);

        // Table-driven lines
        for (int v = 0; v < 7; v++) begin
            run_line(vecs[v].en, vecs[v].stall_max, vecs[v].disturb, vecs[v].exp_cycles);
        end

        // Empty enable mask
        layer_enable = 4'b0000;
        line_start   = 1'b1;
        vram_grant   = 1'b1;
        @(negedge clk);
        line_start = 1'b0;
        chk("empty_done", 32'(done), 1);
        chk("empty_busy", 32'(busy), 0);
        chk("empty_req", 32'(vram_req), 0);
        @(negedge clk);
        chk("empty_done_once", 32'(done), 0);
        chk("empty_busy2", 32'(busy), 0);
        chk("empty_req2", 32'(vram_req), 0);

        // Reset while in MAP_WAIT at column 10
        layer_enable = 4'b1111;
        line_start   = 1'b1;
        vram_grant   = 1'b1;
        @(negedge clk);
        line_start = 1'b0;
        found      = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            if (state_dbg == 2'd2 && column == 6'd10) found = 1'b1;
            else @(negedge clk);
        end
        chk("reach_wait_col10", 32'(found), 1);
        reset = 1'b1;
        #1;
        chk("arst_req", 32'(vram_req), 0);
        chk("arst_kind", 32'(fetch_kind), 0);
        chk("arst_column", 32'(column), 0);
        chk("arst_layer", 32'(layer_index), 0);
        chk("arst_tags", 32'({tile_data_valid, tile_layer, tile_column}), 0);
        chk("arst_busy_done", 32'({busy, done}), 0);
        chk("arst_state", 32'(state_dbg), 0);
        vram_grant = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_no_done", 32'(done), 0);
            chk("post_rst_idle", 32'({busy, vram_req, tile_data_valid}), 0);
        end
        run_line(4'b0100, 0, 1'b0, 96);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
